// File: rtl/branch_resolve_unit.sv
// EX/MEM branch resolution: compares the fetch-time prediction with the real outcome,
// registers the predictor update record, and sequences a multi-cycle wrong-path flush.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_pred_hit,
  input  logic [31:0]      ex_pred_target,
  input  logic             ex_cond_true,
  input  logic [31:0]      ex_target,
  output logic             PCSrc,
  output logic [31:0]      mem_pc,
  output logic [31:0]      t_addr,
  output logic             mem_is_taken,
  output logic             miss_predict,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             pcsrc_q, pcsrc_d;
  logic             miss_predict_q, miss_predict_d;
  logic             mem_is_taken_q, mem_is_taken_d;
  logic [31:0]      mem_pc_q, mem_pc_d;
  logic [31:0]      t_addr_q, t_addr_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [31:0] pc_plus4, act_next, pred_next;
  logic        act_taken, resolve, mis;

  // A jump wins over a simultaneous branch flag, so both-high resolves as taken.
  always_comb begin
    pc_plus4  = ex_pc + 32'd4;
    act_taken = ex_is_jump | (ex_is_branch & ex_cond_true);
    act_next  = act_taken ? ex_target : pc_plus4;
    pred_next = (ex_pred_taken & ex_pred_hit) ? ex_pred_target : pc_plus4;
    resolve   = ex_valid & (ex_is_branch | ex_is_jump) & ~stall & (state_q == IDLE);
    mis       = resolve & (pred_next != act_next);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush_d        = flush_q;
    pcsrc_d        = resolve;
    miss_predict_d = mis;
    mem_pc_d       = mem_pc_q;
    t_addr_d       = t_addr_q;
    mem_is_taken_d = mem_is_taken_q;
    redirect_pc_d  = redirect_pc_q;
    br_cnt_d       = br_cnt_q;
    miss_cnt_d     = miss_cnt_q;

    if (resolve) begin
      mem_pc_d       = ex_pc;
      t_addr_d       = ex_target;
      mem_is_taken_d = act_taken;
      if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mis) begin
      redirect_pc_d = act_next;
      if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end

    // The flush countdown ignores stall: the squash window is fixed in cycles.
    case (state_q)
      IDLE: begin
        if (mis) begin
          state_d = FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES);
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        flush_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      flush_q        <= 1'b0;
      pcsrc_q        <= 1'b0;
      miss_predict_q <= 1'b0;
      mem_is_taken_q <= 1'b0;
      mem_pc_q       <= '0;
      t_addr_q       <= '0;
      redirect_pc_q  <= '0;
      br_cnt_q       <= '0;
      miss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flush_q        <= flush_d;
      pcsrc_q        <= pcsrc_d;
      miss_predict_q <= miss_predict_d;
      mem_is_taken_q <= mem_is_taken_d;
      mem_pc_q       <= mem_pc_d;
      t_addr_q       <= t_addr_d;
      redirect_pc_q  <= redirect_pc_d;
      br_cnt_q       <= br_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  assign PCSrc        = pcsrc_q;
  assign mem_pc       = mem_pc_q;
  assign t_addr       = t_addr_q;
  assign mem_is_taken = mem_is_taken_q;
  assign miss_predict = miss_predict_q;
  assign redirect_pc  = redirect_pc_q;
  assign flush        = flush_q;
  assign br_cnt       = br_cnt_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random stimulus against a
// cycle-level outcome model; a second instance covers FLUSH_CYCLES=3 / CNT_W=4.
module tb_branch_resolve_unit;

  localparam int FC  = 2;
  localparam int MAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, ex_valid, ex_is_branch, ex_is_jump;
  logic [31:0] ex_pc, ex_pred_target, ex_target;
  logic        ex_pred_taken, ex_pred_hit, ex_cond_true;

  logic        PCSrc, mem_is_taken, miss_predict, flush;
  logic [31:0] mem_pc, t_addr, redirect_pc;
  logic [15:0] br_cnt, miss_cnt;

  logic        PCSrc2, mem_is_taken2, miss_predict2, flush2;
  logic [31:0] mem_pc2, t_addr2, redirect_pc2;
  logic [3:0]  br_cnt2, miss_cnt2;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_hit(ex_pred_hit),
    .ex_pred_target(ex_pred_target), .ex_cond_true(ex_cond_true),
    .ex_target(ex_target), .PCSrc(PCSrc), .mem_pc(mem_pc), .t_addr(t_addr),
    .mem_is_taken(mem_is_taken), .miss_predict(miss_predict),
    .redirect_pc(redirect_pc), .flush(flush), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(3), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_hit(ex_pred_hit),
    .ex_pred_target(ex_pred_target), .ex_cond_true(ex_cond_true),
    .ex_target(ex_target), .PCSrc(PCSrc2), .mem_pc(mem_pc2), .t_addr(t_addr2),
    .mem_is_taken(mem_is_taken2), .miss_predict(miss_predict2),
    .redirect_pc(redirect_pc2), .flush(flush2), .br_cnt(br_cnt2), .miss_cnt(miss_cnt2)
  );

  logic [131:0] act_vec;
  assign act_vec = {PCSrc, mem_pc, t_addr, mem_is_taken, miss_predict, redirect_pc,
                    flush, br_cnt, miss_cnt};

  // Outcome model for the default instance: what the predictor update record
  // should contain after each clock, derived from the resolve rules directly.
  logic        m_pcsrc, m_taken, m_mp;
  logic [31:0] m_mem_pc, m_t_addr, m_redirect;
  int          m_flush_left, m_br, m_miss;

  task automatic model_reset();
    m_pcsrc = 0; m_taken = 0; m_mp = 0;
    m_mem_pc = 0; m_t_addr = 0; m_redirect = 0;
    m_flush_left = 0; m_br = 0; m_miss = 0;
  endtask

  function automatic logic [131:0] exp_vec();
    logic [15:0] b, m;
    b = 16'(m_br);
    m = 16'(m_miss);
    return {m_pcsrc, m_mem_pc, m_t_addr, m_taken, m_mp, m_redirect, (m_flush_left > 0), b, m};
  endfunction

  // One clock: predict from current inputs, advance, then sample 1 time unit later.
  task automatic step();
    logic        res, tk, mis;
    logic [31:0] actn, predn;
    res   = ex_valid && (ex_is_branch || ex_is_jump) && !stall && (m_flush_left == 0) && rst;
    tk    = ex_is_jump || (ex_is_branch && ex_cond_true);
    actn  = tk ? ex_target : ex_pc + 32'd4;
    predn = (ex_pred_taken && ex_pred_hit) ? ex_pred_target : ex_pc + 32'd4;
    mis   = res && (predn != actn);
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else begin
      m_pcsrc = res;
      m_mp    = mis;
      if (res) begin
        m_mem_pc = ex_pc; m_t_addr = ex_target; m_taken = tk;
        if (m_br < MAX) m_br++;
      end
      if (mis) begin
        m_redirect = actn;
        if (m_miss < MAX) m_miss++;
        m_flush_left = FC;
      end else if (m_flush_left > 0) m_flush_left--;
    end
  endtask

  task automatic drive_idle();
    stall = 0; ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_pc = 0;
    ex_pred_taken = 0; ex_pred_hit = 0; ex_pred_target = 0; ex_cond_true = 0; ex_target = 0;
  endtask

  task automatic drive_br(input logic br, input logic jmp, input logic [31:0] pc,
                          input logic pt, input logic ph, input logic [31:0] ptgt,
                          input logic cond, input logic [31:0] tgt);
    stall = 0; ex_valid = 1; ex_is_branch = br; ex_is_jump = jmp; ex_pc = pc;
    ex_pred_taken = pt; ex_pred_hit = ph; ex_pred_target = ptgt;
    ex_cond_true = cond; ex_target = tgt;
  endtask

  task automatic test_reset();
    rst = 0;
    drive_br(1, 0, 32'h100, 0, 0, 0, 1, 32'h180);
    #7;
    chk_cnt++;
    if ({act_vec, PCSrc2, flush2} !== '0) $display("FAIL reset_async act=%h exp=0", act_vec);
    else pass_cnt++;
    model_reset();
    step();
    chk_cnt++;
    if ({act_vec, PCSrc2, flush2} !== '0) $display("FAIL reset_held act=%h exp=0", act_vec);
    else pass_cnt++;
    drive_idle();
    rst = 1;
    step(); step();
    chk_cnt++;
    if (act_vec !== '0 || act_vec !== exp_vec())
      $display("FAIL reset_release act=%h exp=0", act_vec);
    else pass_cnt++;
  endtask

  task automatic test_not_taken();
    drive_br(1, 0, 32'h100, 0, 0, 0, 0, 32'h140);
    step();
    drive_idle();
    chk_cnt++;
    if ({PCSrc, mem_pc, mem_is_taken, miss_predict, flush, br_cnt, miss_cnt} !==
        {1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0})
      $display("FAIL not_taken act=%b/%h/%b/%b/%b/%0d/%0d", PCSrc, mem_pc, mem_is_taken,
               miss_predict, flush, br_cnt, miss_cnt);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({PCSrc, mem_pc} !== {1'b0, 32'h100}) $display("FAIL pcsrc_pulse act=%b/%h exp=0/100", PCSrc, mem_pc);
    else pass_cnt++;
  endtask

  task automatic test_mispredict();
    drive_br(1, 0, 32'h200, 0, 0, 0, 1, 32'h180);
    step();
    drive_br(1, 0, 32'h300, 0, 0, 0, 0, 32'h380);
    chk_cnt++;
    if ({PCSrc, miss_predict, redirect_pc, mem_is_taken, flush, br_cnt, miss_cnt} !==
        {1'b1, 1'b1, 32'h180, 1'b1, 1'b1, 16'd2, 16'd1})
      $display("FAIL mispredict act=%b/%b/%h/%b/%b/%0d/%0d exp=1/1/180/1/1/2/1", PCSrc,
               miss_predict, redirect_pc, mem_is_taken, flush, br_cnt, miss_cnt);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({PCSrc, miss_predict, flush, br_cnt} !== {1'b0, 1'b0, 1'b1, 16'd2})
      $display("FAIL flush_cyc2 act=%b/%b/%b/%0d exp=0/0/1/2", PCSrc, miss_predict, flush, br_cnt);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({PCSrc, flush, br_cnt, miss_cnt} !== {1'b0, 1'b0, 16'd2, 16'd1})
      $display("FAIL flush_end act=%b/%b/%0d/%0d exp=0/0/2/1", PCSrc, flush, br_cnt, miss_cnt);
    else pass_cnt++;
    step();
    drive_idle();
    chk_cnt++;
    if ({PCSrc, mem_pc, miss_predict, br_cnt} !== {1'b1, 32'h300, 1'b0, 16'd3})
      $display("FAIL after_flush act=%b/%h/%b/%0d exp=1/300/0/3", PCSrc, mem_pc, miss_predict, br_cnt);
    else pass_cnt++;
    step();
  endtask

  task automatic test_wrong_target();
    drive_br(0, 1, 32'h500, 1, 1, 32'h400, 0, 32'h480);
    step();
    drive_idle();
    chk_cnt++;
    if ({miss_predict, redirect_pc, mem_is_taken, t_addr, flush} !==
        {1'b1, 32'h480, 1'b1, 32'h480, 1'b1} || act_vec !== exp_vec())
      $display("FAIL wrong_target act=%b/%h/%b/%h exp=1/480/1/480", miss_predict, redirect_pc,
               mem_is_taken, t_addr);
    else pass_cnt++;
    step(); step();
    drive_br(1, 0, 32'h600, 1, 0, 32'h700, 0, 32'h700);
    step();
    drive_idle();
    chk_cnt++;
    if ({PCSrc, miss_predict, mem_is_taken, flush, redirect_pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h480})
      $display("FAIL btb_miss_nt act=%b/%b/%b/%b/%h exp=1/0/0/0/480", PCSrc, miss_predict,
               mem_is_taken, flush, redirect_pc);
    else pass_cnt++;
  endtask

  task automatic test_wrap_stall();
    drive_br(1, 0, 32'hFFFF_FFFC, 1, 1, 32'h0, 0, 32'h10);
    step();
    chk_cnt++;
    if ({PCSrc, miss_predict, mem_is_taken, mem_pc, flush} !== {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0})
      $display("FAIL pc_wrap act=%b/%b/%b/%h exp=1/0/0/fffffffc", PCSrc, miss_predict, mem_is_taken, mem_pc);
    else pass_cnt++;
    drive_br(1, 0, 32'h800, 1, 1, 32'h900, 1, 32'h900);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cnt++;
      if ({PCSrc, miss_predict, mem_pc} !== {1'b0, 1'b0, 32'hFFFF_FFFC} || act_vec !== exp_vec())
        $display("FAIL stall_hold cyc=%0d act=%b/%b/%h exp=0/0/fffffffc", i, PCSrc, miss_predict, mem_pc);
      else pass_cnt++;
    end
    stall = 0;
    step();
    drive_idle();
    chk_cnt++;
    if ({PCSrc, mem_pc, mem_is_taken} !== {1'b1, 32'h800, 1'b1})
      $display("FAIL stall_release act=%b/%h/%b exp=1/800/1", PCSrc, mem_pc, mem_is_taken);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (PCSrc !== 1'b0) $display("FAIL stall_single act=%b exp=0", PCSrc);
    else pass_cnt++;
  endtask

  task automatic test_both_flags();
    drive_br(1, 1, 32'h1000, 1, 1, 32'h2000, 0, 32'h2000);
    step();
    drive_idle();
    chk_cnt++;
    if ({PCSrc, mem_is_taken, miss_predict} !== 3'b110 || act_vec !== exp_vec())
      $display("FAIL both_flags act=%b/%b/%b exp=1/1/0", PCSrc, mem_is_taken, miss_predict);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_br(1, 0, 32'h3000 + 32'(i * 8), 0, 0, 0, 0, 32'h4000);
      step();
      chk_cnt++;
      if ({PCSrc, mem_pc, miss_predict} !== {1'b1, 32'h3000 + 32'(i * 8), 1'b0} || act_vec !== exp_vec())
        $display("FAIL back_to_back i=%0d act=%b/%h exp=1/%h", i, PCSrc, mem_pc, 32'h3000 + 32'(i * 8));
      else pass_cnt++;
    end
    drive_idle();
    step();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_is_branch  = $urandom_range(0, 1);
      ex_is_jump    = ($urandom_range(0, 3) == 0);
      ex_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 255), 2'b00};
      ex_target     = {$urandom_range(0, 255), 2'b00};
      ex_pred_taken = $urandom_range(0, 1);
      ex_pred_hit   = ($urandom_range(0, 3) != 0);
      ex_pred_target = $urandom_range(0, 1) ? ex_target : ex_pc + 32'd4;
      ex_cond_true  = $urandom_range(0, 1);
      stall         = ($urandom_range(0, 4) == 0);
      step();
      chk_cnt++;
      if (act_vec !== exp_vec()) begin
        if (errs < 10) $display("FAIL random cyc=%0d act=%h exp=%h", i, act_vec, exp_vec());
        errs++;
      end else pass_cnt++;
    end
    drive_idle();
  endtask

  task automatic pulse_reset();
    rst = 0;
    #2;
    rst = 1;
    model_reset();
  endtask

  task automatic test_flush3();
    pulse_reset();
    drive_br(1, 0, 32'h200, 0, 0, 0, 1, 32'h180);
    step();
    drive_idle();
    chk_cnt++;
    if ({miss_predict2, redirect_pc2, flush2} !== {1'b1, 32'h180, 1'b1})
      $display("FAIL flush3_start act=%b/%h/%b exp=1/180/1", miss_predict2, redirect_pc2, flush2);
    else pass_cnt++;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_cnt++;
      if (flush2 !== (i <= 3)) $display("FAIL flush3_len cyc=%0d act=%b exp=%b", i, flush2, (i <= 3));
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset_mid_flush();
    drive_br(1, 0, 32'h200, 0, 0, 0, 1, 32'h180);
    step();
    drive_idle();
    step();
    #2;
    rst = 0;
    #1;
    chk_cnt++;
    if ({flush2, miss_predict2, br_cnt2, miss_cnt2, flush} !== '0)
      $display("FAIL reset_mid_flush act=%b/%b/%0d/%0d/%b exp=0", flush2, miss_predict2, br_cnt2,
               miss_cnt2, flush);
    else pass_cnt++;
    model_reset();
    #2;
    rst = 1;
    drive_br(1, 0, 32'h700, 0, 0, 0, 0, 32'h780);
    step();
    drive_idle();
    chk_cnt++;
    if ({PCSrc2, flush2, mem_pc2, br_cnt2} !== {1'b1, 1'b0, 32'h700, 4'd1})
      $display("FAIL idle_after_reset act=%b/%b/%h/%0d exp=1/0/700/1", PCSrc2, flush2, mem_pc2, br_cnt2);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    pulse_reset();
    drive_br(1, 0, 32'h100, 0, 0, 0, 0, 32'h140);
    repeat (15) step();
    chk_cnt++;
    if (br_cnt2 !== 4'd15) $display("FAIL br_preload act=%0d exp=15", br_cnt2);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({PCSrc2, br_cnt2} !== {1'b1, 4'd15}) $display("FAIL br_saturate act=%b/%0d exp=1/15", PCSrc2, br_cnt2);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      drive_br(1, 0, 32'h200, 0, 0, 0, 1, 32'h180);
      step();
      drive_idle();
      if (i == 15) begin
        chk_cnt++;
        if ({miss_predict2, miss_cnt2, br_cnt2} !== {1'b1, 4'd15, 4'd15})
          $display("FAIL miss_saturate act=%b/%0d/%0d exp=1/15/15", miss_predict2, miss_cnt2, br_cnt2);
        else pass_cnt++;
      end
      repeat (3) step();
    end
    chk_cnt++;
    if (act_vec !== exp_vec()) $display("FAIL wide_counts act=%h exp=%h", act_vec, exp_vec());
    else pass_cnt++;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_not_taken();
    test_mispredict();
    test_wrong_target();
    test_wrap_stall();
    test_both_flags();
    test_back_to_back();
    test_random();
    test_flush3();
    test_async_reset_mid_flush();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
